// File: rtl/regfile_pkg.sv
// Shared types and constants for the scoreboarded register file.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  localparam int ZERO_REG = 0;

  function automatic int nregs(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write busy bits: issue sets, write clears, clr_all wipes everything.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              clr_all,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic              busy_a,
  output logic              busy_b
);

  logic [NREGS-1:0] r_busy;

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_busy
      // Set beats clear so a same-cycle issue (the newer reservation) survives the write.
      always_ff @(posedge clk) begin
        if (clr_all) begin
          r_busy[gi] <= 1'b0;
        end else if (set_en && (set_addr == ADDR_W'(gi)) && (gi != ZERO_REG)) begin
          r_busy[gi] <= 1'b1;
        end else if (clr_en && (clr_addr == ADDR_W'(gi))) begin
          r_busy[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  assign busy_a = r_busy[rd_addr_a];
  assign busy_b = r_busy[rd_addr_b];

endmodule

// File: rtl/reg_file_sb.sv
// Register file with busy scoreboard and post-reset/on-request clear sweep; r0 reads as zero.
// Define REGFILE_BYPASS_EN to forward a same-cycle write to the read ports.
module reg_file_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] addr_write,
  input  logic [DATA_W-1:0] write_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              clear_req,
  input  logic [ADDR_W-1:0] addr_A,
  input  logic [ADDR_W-1:0] addr_B,
  output logic [DATA_W-1:0] data_A,
  output logic [DATA_W-1:0] data_B,
  output logic              busy_A,
  output logic              busy_B,
  output logic              ready
);

  localparam int NREGS = nregs(ADDR_W);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] r_regs [NREGS];
  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] w_idx_next;
  logic              w_idle;
  logic              w_sweep_start;
  logic              w_user_write;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_busy_a;
  logic              w_busy_b;
  logic [ADDR_W-1:0] w_raddr [2];
  logic [DATA_W-1:0] w_rdata [2];

  // Gating with rst_n keeps outputs quiet during reset even before the first edge.
  assign w_idle        = rst_n && (r_state == IDLE);
  assign w_sweep_start = w_idle && clear_req;
  assign w_user_write  = w_idle && reg_write && (addr_write != ZERO_IDX);

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    case (r_state)
      CLEAR: begin
        w_idx_next = r_idx + 1'b1;
        if (r_idx == LAST_IDX) begin
          w_state_next = IDLE;
        end
      end
      IDLE: begin
        if (clear_req) begin
          w_state_next = CLEAR;
          w_idx_next   = ADDR_W'(1);
        end
      end
      default: begin
        w_state_next = CLEAR;
        w_idx_next   = ADDR_W'(1);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= CLEAR;
      r_idx   <= ADDR_W'(1);
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  // Single write port shared by the sweep and normal writes.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = addr_write;
    w_wdata = write_data;
    if (rst_n && (r_state == CLEAR)) begin
      w_we    = 1'b1;
      w_waddr = r_idx;
      w_wdata = '0;
    end else if (w_user_write) begin
      w_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_regs[w_waddr] <= w_wdata;
    end
  end

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk       (clk),
    .clr_all   (!rst_n || w_sweep_start),
    .set_en    (w_idle && issue_valid),
    .set_addr  (issue_addr),
    .clr_en    (w_user_write),
    .clr_addr  (addr_write),
    .rd_addr_a (addr_A),
    .rd_addr_b (addr_B),
    .busy_a    (w_busy_a),
    .busy_b    (w_busy_b)
  );

  assign w_raddr[0] = addr_A;
  assign w_raddr[1] = addr_B;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_read
      always_comb begin
        w_rdata[gi] = '0;
        if (w_idle && (w_raddr[gi] != ZERO_IDX)) begin
`ifdef REGFILE_BYPASS_EN
          if (w_user_write && (addr_write == w_raddr[gi])) begin
            w_rdata[gi] = write_data;
          end else begin
            w_rdata[gi] = r_regs[w_raddr[gi]];
          end
`else
          w_rdata[gi] = r_regs[w_raddr[gi]];
`endif
        end
      end
    end
  endgenerate

  assign data_A = w_rdata[0];
  assign data_B = w_rdata[1];
  assign busy_A = w_idle && (addr_A != ZERO_IDX) && w_busy_a;
  assign busy_B = w_idle && (addr_B != ZERO_IDX) && w_busy_b;
  assign ready  = w_idle;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb (DATA_W=8, ADDR_W=3); follows REGFILE_BYPASS_EN if defined.
module tb_reg_file_sb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       reg_write;
  logic [2:0] addr_write;
  logic [7:0] write_data;
  logic       issue_valid;
  logic [2:0] issue_addr;
  logic       clear_req;
  logic [2:0] addr_A;
  logic [2:0] addr_B;
  logic [7:0] data_A;
  logic [7:0] data_B;
  logic       busy_A;
  logic       busy_B;
  logic       ready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reg_file_sb #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .reg_write   (reg_write),
    .addr_write  (addr_write),
    .write_data  (write_data),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .clear_req   (clear_req),
    .addr_A      (addr_A),
    .addr_B      (addr_B),
    .data_A      (data_A),
    .data_B      (data_B),
    .busy_A      (busy_A),
    .busy_B      (busy_B),
    .ready       (ready)
  );

  // Advance past the next rising edge; inputs change and outputs are sampled off-edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int cnt;
    rst_n = 1'b0; reg_write = 1'b0; addr_write = '0; write_data = '0;
    issue_valid = 1'b0; issue_addr = '0; clear_req = 1'b0; addr_A = 3'd1; addr_B = 3'd2;
    step(); step(); step();
    n_checks++;
    if (ready !== 1'b0 || data_A !== 8'h00 || busy_A !== 1'b0 || busy_B !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b data_A=%h busy_A=%b busy_B=%b, required 0/00/0/0",
               ready, data_A, busy_A, busy_B);
    end
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (ready === 1'b1) break;
      cnt++;
      step();
    end
    n_checks++;
    if (cnt !== 7) begin
      n_fail++;
      $display("FAIL reset_sweep_len: ready low for %0d cycles, required 7", cnt);
    end
    for (int r = 1; r < 8; r++) begin
      addr_A = 3'(r);
      #1;
      n_checks++;
      if (data_A !== 8'h00 || busy_A !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_read_r%0d: data_A=%h busy_A=%b, required 00/0", r, data_A, busy_A);
      end
    end
    $display("test_reset: sweep %0d cycles, r1..r7 read", cnt);
  endtask

  task automatic test_write_bypass();
    logic [7:0] exp_same;
`ifdef REGFILE_BYPASS_EN
    exp_same = 8'h05;
`else
    exp_same = 8'h00;
`endif
    reg_write = 1'b1; addr_write = 3'd4; write_data = 8'h05; addr_A = 3'd4;
    #1;
    n_checks++;
    if (data_A !== exp_same) begin
      n_fail++;
      $display("FAIL write_same_cycle: data_A=%h, required %h", data_A, exp_same);
    end
    step();
    reg_write = 1'b0;
    #1;
    n_checks++;
    if (data_A !== 8'h05) begin
      n_fail++;
      $display("FAIL write_next_cycle: data_A=%h, required 05", data_A);
    end
    $display("test_write_bypass: r4 same=%h next=%h", exp_same, data_A);
  endtask

  task automatic test_r0();
    reg_write = 1'b1; addr_write = 3'd0; write_data = 8'hFF; addr_A = 3'd0;
    issue_valid = 1'b1; issue_addr = 3'd0;
    #1;
    n_checks++;
    if (data_A !== 8'h00) begin
      n_fail++;
      $display("FAIL r0_same_cycle: data_A=%h, required 00", data_A);
    end
    step();
    reg_write = 1'b0; issue_valid = 1'b0;
    #1;
    n_checks++;
    if (data_A !== 8'h00 || busy_A !== 1'b0) begin
      n_fail++;
      $display("FAIL r0_read: data_A=%h busy_A=%b, required 00/0", data_A, busy_A);
    end
    $display("test_r0: data_A=%h busy_A=%b", data_A, busy_A);
  endtask

  task automatic test_scoreboard();
    addr_B = 3'd3; issue_valid = 1'b1; issue_addr = 3'd3;
    #1;
    n_checks++;
    if (busy_B !== 1'b0) begin
      n_fail++;
      $display("FAIL issue_same_cycle: busy_B=%b, required 0", busy_B);
    end
    step();
    issue_valid = 1'b0;
    #1;
    n_checks++;
    if (busy_B !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_set: busy_B=%b, required 1", busy_B);
    end
    reg_write = 1'b1; addr_write = 3'd3; write_data = 8'h2A;
    #1;
    n_checks++;
    if (busy_B !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_not_bypassed: busy_B=%b, required 1", busy_B);
    end
    step();
    reg_write = 1'b0;
    #1;
    n_checks++;
    if (busy_B !== 1'b0 || data_B !== 8'h2A) begin
      n_fail++;
      $display("FAIL write_clears_busy: busy_B=%b data_B=%h, required 0/2a", busy_B, data_B);
    end
    reg_write = 1'b1; addr_write = 3'd3; write_data = 8'h3C;
    issue_valid = 1'b1; issue_addr = 3'd3;
    step();
    reg_write = 1'b0; issue_valid = 1'b0;
    #1;
    n_checks++;
    if (busy_B !== 1'b1 || data_B !== 8'h3C) begin
      n_fail++;
      $display("FAIL issue_wins: busy_B=%b data_B=%h, required 1/3c", busy_B, data_B);
    end
    $display("test_scoreboard: r3 busy=%b data=%h", busy_B, data_B);
  endtask

  task automatic test_clear_sweep();
    int cnt;
    reg_write = 1'b1; addr_write = 3'd2; write_data = 8'h11;
    step();
    reg_write = 1'b0; addr_A = 3'd2;
    #1;
    n_checks++;
    if (data_A !== 8'h11) begin
      n_fail++;
      $display("FAIL pre_sweep_r2: data_A=%h, required 11", data_A);
    end
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    reg_write = 1'b1; addr_write = 3'd5; write_data = 8'h77;
    issue_valid = 1'b1; issue_addr = 3'd6;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (ready === 1'b1) break;
      if (data_A !== 8'h00 || busy_B !== 1'b0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sweep_outputs: data_A=%h busy_B=%b, required 00/0", data_A, busy_B);
      end
      cnt++;
      step();
    end
    reg_write = 1'b0; issue_valid = 1'b0;
    n_checks++;
    if (cnt !== 7) begin
      n_fail++;
      $display("FAIL clear_sweep_len: ready low for %0d cycles, required 7", cnt);
    end
    addr_A = 3'd2; addr_B = 3'd3;
    #1;
    n_checks++;
    if (data_A !== 8'h00 || busy_B !== 1'b0) begin
      n_fail++;
      $display("FAIL post_sweep_r2_r3: data_A=%h busy_B=%b, required 00/0", data_A, busy_B);
    end
    addr_A = 3'd5; addr_B = 3'd6;
    #1;
    n_checks++;
    if (data_A !== 8'h00 || busy_B !== 1'b0) begin
      n_fail++;
      $display("FAIL sweep_ignores_inputs: data_A=%h busy_B=%b, required 00/0", data_A, busy_B);
    end
    $display("test_clear_sweep: sweep %0d cycles, r2=%h", cnt, data_A);
  endtask

  task automatic test_reset_mid_sweep();
    int cnt;
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    step(); step();
    rst_n = 1'b0;
    step();
    #1;
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_sweep_reset_ready: ready=%b, required 0", ready);
    end
    step();
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (ready === 1'b1) break;
      cnt++;
      step();
    end
    n_checks++;
    if (cnt !== 7) begin
      n_fail++;
      $display("FAIL mid_sweep_restart_len: ready low for %0d cycles, required 7", cnt);
    end
    $display("test_reset_mid_sweep: restart sweep %0d cycles", cnt);
  endtask

  initial begin
    test_reset();
    test_write_bypass();
    test_r0();
    test_scoreboard();
    test_clear_sweep();
    test_reset_mid_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
